transaccion: RTL and testbench

//  ATM transaction engine; responder side of the card/amount/balance interface driven by the session front end.

---
 rtl/transaccion_if.sv | 48 ++++
 rtl/transaccion.sv | 162 ++++++++++++++++
 tb/tb_transaccion.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/transaccion_if.sv
// Card / amount / balance bus between the session front end and the
// transaction engine.
//   master : front end (drives card level, request strobe, amount, balance)
//   slave  : transaction engine (drives balance, strobes, dispense, flags)
interface transaccion_if #(
    parameter int ANCHO_MONTO   = 32,
    parameter int ANCHO_BALANCE = 64
);
    logic                     tarjeta_recibida;
    logic                     tipo_trans;
    logic [ANCHO_MONTO-1:0]   monto;
    logic                     monto_stb;
    logic [ANCHO_BALANCE-1:0] balance_inicial;
    logic [ANCHO_BALANCE-1:0] balance_actualizado;
    logic                     balance_stb;
    logic                     entregar_dinero;
    logic                     fondos_insuficientes;
    logic                     limite_excedido;
    logic                     ocupado;

    modport master (
        output tarjeta_recibida,
        output tipo_trans,
        output monto,
        output monto_stb,
        output balance_inicial,
        input  balance_actualizado,
        input  balance_stb,
        input  entregar_dinero,
        input  fondos_insuficientes,
        input  limite_excedido,
        input  ocupado
    );

    modport slave (
        input  tarjeta_recibida,
        input  tipo_trans,
        input  monto,
        input  monto_stb,
        input  balance_inicial,
        output balance_actualizado,
        output balance_stb,
        output entregar_dinero,
        output fondos_insuficientes,
        output limite_excedido,
        output ocupado
    );
endinterface

// File: rtl/transaccion.sv
// ATM transaction engine (responder side of the card/amount/balance bus).
// Loads the account balance on card insertion, then executes deposits and
// withdrawals on strobed amounts, reporting each result with a one-cycle
// balance strobe plus a dispense command or a rejection flag.
//
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : transaccion_if.slave (card level, request, balance, result pulses)
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | no card; waits for tarjeta_recibida, then loads the balance
// ESPERA| card present; waits for a request strobe
// EJECUTA| one cycle; latched request is executed on the exiting edge
//
// Result timing: the balance register and result flags update on the edge
// leaving EJECUTA; the bus outputs are a registered copy of those, so the
// pulses appear one cycle later (strobe sampled at edge k -> pulses k+2..k+3).
module transaccion #(
    parameter int ANCHO_MONTO   = 32,
    parameter int ANCHO_BALANCE = 64,
    parameter int LIMITE_RETIRO = 5000
) (
    input  logic          clk,
    input  logic          reset,
    transaccion_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ESPERA  = 2'd1,
        EJECUTA = 2'd2
    } estado_t;

    localparam logic [ANCHO_MONTO:0] LIMITE = (ANCHO_MONTO+1)'(LIMITE_RETIRO);

    estado_t                  estado;
    logic [ANCHO_BALANCE-1:0] balance;
    logic [ANCHO_MONTO-1:0]   retirado_sesion;
    logic [ANCHO_MONTO-1:0]   monto_lat;
    logic                     tipo_lat;

    // one-cycle result flags, copied onto the bus on the following edge
    logic                     res_stb;
    logic                     res_entregar;
    logic                     res_fondos;
    logic                     res_limite;

    // combinational execution of the latched request
    logic [ANCHO_BALANCE-1:0] monto_ext;
    logic [ANCHO_BALANCE:0]   suma_deposito;
    logic [ANCHO_MONTO:0]     suma_retiro;
    logic [ANCHO_BALANCE-1:0] balance_sig;
    logic [ANCHO_MONTO-1:0]   retirado_sig;
    logic                     entregar_sig;
    logic                     fondos_sig;
    logic                     limite_sig;

    assign monto_ext     = ANCHO_BALANCE'(monto_lat);
    assign suma_deposito = {1'b0, balance} + {1'b0, monto_ext};
    // one extra bit so the session-limit sum never wraps
    assign suma_retiro   = {1'b0, retirado_sesion} + {1'b0, monto_lat};

    always_comb begin
        balance_sig  = balance;
        retirado_sig = retirado_sesion;
        entregar_sig = 1'b0;
        fondos_sig   = 1'b0;
        limite_sig   = 1'b0;
        if (monto_lat == '0) begin
            // zero amount: only the balance strobe is reported
        end else if (!tipo_lat) begin
            if (suma_deposito[ANCHO_BALANCE]) begin
                balance_sig = '1;
            end else begin
                balance_sig = suma_deposito[ANCHO_BALANCE-1:0];
            end
        end else if (monto_ext > balance) begin
            fondos_sig = 1'b1;
        end else if (suma_retiro > LIMITE) begin
            limite_sig = 1'b1;
        end else begin
            balance_sig  = balance - monto_ext;
            // bounded by LIMITE, so the carry bit is always clear here
            retirado_sig = suma_retiro[ANCHO_MONTO-1:0];
            entregar_sig = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado                   <= IDLE;
            balance                  <= '0;
            retirado_sesion          <= '0;
            monto_lat                <= '0;
            tipo_lat                 <= 1'b0;
            res_stb                  <= 1'b0;
            res_entregar             <= 1'b0;
            res_fondos               <= 1'b0;
            res_limite               <= 1'b0;
            bus.balance_actualizado  <= '0;
            bus.balance_stb          <= 1'b0;
            bus.entregar_dinero      <= 1'b0;
            bus.fondos_insuficientes <= 1'b0;
            bus.limite_excedido      <= 1'b0;
            bus.ocupado              <= 1'b0;
        end else begin
            res_stb      <= 1'b0;
            res_entregar <= 1'b0;
            res_fondos   <= 1'b0;
            res_limite   <= 1'b0;

            bus.balance_actualizado  <= balance;
            bus.balance_stb          <= res_stb;
            bus.entregar_dinero      <= res_entregar;
            bus.fondos_insuficientes <= res_fondos;
            bus.limite_excedido      <= res_limite;

            case (estado)
                IDLE: begin
                    bus.ocupado <= 1'b0;
                    if (bus.tarjeta_recibida) begin
                        balance         <= bus.balance_inicial;
                        retirado_sesion <= '0;
                        estado          <= ESPERA;
                    end
                end
                ESPERA: begin
                    // card removal wins over a same-cycle request
                    if (!bus.tarjeta_recibida) begin
                        bus.ocupado <= 1'b0;
                        estado      <= IDLE;
                    end else if (bus.monto_stb) begin
                        monto_lat   <= bus.monto;
                        tipo_lat    <= bus.tipo_trans;
                        bus.ocupado <= 1'b1;
                        estado      <= EJECUTA;
                    end else begin
                        bus.ocupado <= 1'b0;
                    end
                end
                EJECUTA: begin
                    // the request completes even if the card was just removed
                    balance         <= balance_sig;
                    retirado_sesion <= retirado_sig;
                    res_stb         <= 1'b1;
                    res_entregar    <= entregar_sig;
                    res_fondos      <= fondos_sig;
                    res_limite      <= limite_sig;
                    bus.ocupado     <= 1'b0;
                    estado          <= bus.tarjeta_recibida ? ESPERA : IDLE;
                end
                default: begin
                    bus.ocupado <= 1'b0;
                    estado      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transaccion.sv
// Directed bench for the ATM transaction engine.
module tb_transaccion;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    transaccion_if #(.ANCHO_MONTO(32), .ANCHO_BALANCE(64)) bus_if ();

    transaccion #(
        .ANCHO_MONTO   (32),
        .ANCHO_BALANCE (64),
        .LIMITE_RETIRO (5000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {balance_stb, entregar_dinero, fondos_insuficientes, limite_excedido}
    function automatic logic [3:0] flags();
        return {bus_if.balance_stb, bus_if.entregar_dinero,
                bus_if.fondos_insuficientes, bus_if.limite_excedido};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Issues one request from ESPERA at a negedge and checks the full
    // response window; returns at a negedge with the engine back in ESPERA.
    task automatic peticion(input string tag, input logic tipo, input logic [31:0] m,
                            input logic [63:0] bal_esp, input logic [3:0] flags_esp);
        bus_if.tipo_trans = tipo;
        bus_if.monto      = m;
        bus_if.monto_stb  = 1'b1;
        @(negedge clk);
        bus_if.monto_stb  = 1'b0;
        chk({tag, "_ocupado"}, 64'(bus_if.ocupado), 64'd1);
        @(negedge clk);
        chk({tag, "_early"}, 64'(flags()), 64'd0);
        chk({tag, "_ocupado_off"}, 64'(bus_if.ocupado), 64'd0);
        @(negedge clk);
        chk({tag, "_flags"}, 64'(flags()), 64'(flags_esp));
        chk({tag, "_balance"}, bus_if.balance_actualizado, bal_esp);
        @(negedge clk);
        chk({tag, "_pulse_end"}, 64'(flags()), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus_if.tarjeta_recibida = 1'b0;
        bus_if.tipo_trans       = 1'b0;
        bus_if.monto            = '0;
        bus_if.monto_stb        = 1'b0;
        bus_if.balance_inicial  = 64'd1000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_flags", 64'(flags()), 64'd0);
        chk("reset_balance", bus_if.balance_actualizado, 64'd0);
        chk("reset_ocupado", 64'(bus_if.ocupado), 64'd0);

        // strobe with no card is ignored
        bus_if.monto     = 32'd77;
        bus_if.monto_stb = 1'b1;
        @(negedge clk);
        bus_if.monto_stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_stb_ignored", 64'(flags()), 64'd0);

        // T1: card insertion loads the balance, visible two cycles later
        bus_if.tarjeta_recibida = 1'b1;
        @(negedge clk);
        chk("load_lag", bus_if.balance_actualizado, 64'd0);
        @(negedge clk);
        chk("load_balance", bus_if.balance_actualizado, 64'd1000);
        chk("load_no_stb", 64'(flags()), 64'd0);

        // T2..T4
        peticion("dep100",  1'b0, 32'd100,  64'd1100, 4'b1000);
        peticion("ret50",   1'b1, 32'd50,   64'd1050, 4'b1100);
        peticion("ret2000", 1'b1, 32'd2000, 64'd1050, 4'b1010);
        peticion("ret1050", 1'b1, 32'd1050, 64'd0,    4'b1100);

        // T6a: card removal together with a strobe drops the request
        bus_if.tarjeta_recibida = 1'b0;
        bus_if.tipo_trans       = 1'b0;
        bus_if.monto            = 32'd10;
        bus_if.monto_stb        = 1'b1;
        @(negedge clk);
        bus_if.monto_stb = 1'b0;
        chk("drop_ocupado", 64'(bus_if.ocupado), 64'd0);
        @(negedge clk);
        chk("drop_flags1", 64'(flags()), 64'd0);
        @(negedge clk);
        chk("drop_flags2", 64'(flags()), 64'd0);
        chk("drop_balance_hold", bus_if.balance_actualizado, 64'd0);

        // T5: session withdrawal limit
        bus_if.balance_inicial  = 64'd10000;
        bus_if.tarjeta_recibida = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("load10000", bus_if.balance_actualizado, 64'd10000);
        peticion("ret4000", 1'b1, 32'd4000, 64'd6000, 4'b1100);
        peticion("ret1001", 1'b1, 32'd1001, 64'd6000, 4'b1001);
        peticion("ret1000", 1'b1, 32'd1000, 64'd5000, 4'b1100);
        peticion("ret0",    1'b1, 32'd0,    64'd5000, 4'b1000);
        peticion("ret1",    1'b1, 32'd1,    64'd5000, 4'b1001);
        peticion("dep0",    1'b0, 32'd0,    64'd5000, 4'b1000);

        // card removed while executing: request still completes
        bus_if.tipo_trans = 1'b0;
        bus_if.monto      = 32'd5;
        bus_if.monto_stb  = 1'b1;
        @(negedge clk);
        bus_if.monto_stb        = 1'b0;
        bus_if.tarjeta_recibida = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("remove_exec_flags", 64'(flags()), 64'b1000);
        chk("remove_exec_balance", bus_if.balance_actualizado, 64'd5005);
        bus_if.monto_stb = 1'b1;
        @(negedge clk);
        bus_if.monto_stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("after_remove_idle", 64'(flags()), 64'd0);

        // deposit saturation
        bus_if.balance_inicial  = 64'hFFFF_FFFF_FFFF_FF00;
        bus_if.tarjeta_recibida = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("load_high", bus_if.balance_actualizado, 64'hFFFF_FFFF_FFFF_FF00);
        peticion("dep_ff",  1'b0, 32'h0000_00FF, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
        peticion("dep_sat", 1'b0, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);

        // T6b: reset during EJECUTA aborts without pulses
        bus_if.tipo_trans = 1'b1;
        bus_if.monto      = 32'd100;
        bus_if.monto_stb  = 1'b1;
        @(negedge clk);
        bus_if.monto_stb = 1'b0;
        chk("rst_exec_ocupado", 64'(bus_if.ocupado), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_exec_flags", 64'(flags()), 64'd0);
        chk("rst_exec_balance", bus_if.balance_actualizado, 64'd0);
        chk("rst_exec_ocupado0", 64'(bus_if.ocupado), 64'd0);
        @(negedge clk);
        chk("rst_exec_flags2", 64'(flags()), 64'd0);
        chk("rst_exec_lag", bus_if.balance_actualizado, 64'd0);
        @(negedge clk);
        chk("rst_exec_flags3", 64'(flags()), 64'd0);
        chk("rst_reload", bus_if.balance_actualizado, 64'hFFFF_FFFF_FFFF_FF00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
